// File: rtl/fft_frame_collector.sv
// Serial-to-parallel input stage of the FFT datapath: gathers N samples per frame
// into a collection buffer and hands complete frames to a double-buffered output.
module fft_frame_collector #(
  parameter int N  = 16,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [31:0]            s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [31:0]            frame [0:N-1],
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [$clog2(N+1)-1:0] fill_level,
  output logic [CW-1:0]          frame_cnt
);
  localparam int FW = $clog2(N+1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   coll_q  [0:N-1];
  logic [31:0]   frame_q [0:N-1];
  logic [31:0]   frame_d [0:N-1];

  logic accept, pop, slot_free, last, xfer_fill, xfer_wait, xfer;

  // Ready depends only on state so upstream never sees a combinational loop.
  assign s_ready   = (state_q == FILL);
  assign accept    = s_valid && s_ready && !clear;
  assign pop       = valid_q && frame_ready;
  assign slot_free = !valid_q || frame_ready;
  assign last      = accept && (fill_q == FW'(N - 1));
  assign xfer_fill = last && slot_free;
  assign xfer_wait = (state_q == WAIT) && pop && !clear;
  assign xfer      = xfer_fill || xfer_wait;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;

    // The Nth sample bypasses the collection buffer straight into the output.
    if (xfer_fill) begin
      for (int i = 0; i < N - 1; i++) frame_d[i] = coll_q[i];
      frame_d[N-1] = s_data;
    end else if (xfer_wait) begin
      frame_d = coll_q;
    end

    if (xfer) begin
      valid_d = 1'b1;
      cnt_d   = cnt_q + CW'(1);
    end else if (pop) begin
      valid_d = 1'b0;
    end

    if (clear || xfer) begin
      fill_d  = '0;
      state_d = FILL;
    end else if (accept) begin
      fill_d = fill_q + FW'(1);
      if (last) state_d = WAIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      fill_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < N; i++) frame_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // Buffer contents need no reset: fill_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (accept && (fill_q == FW'(i))) coll_q[i] <= s_data;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign fill_level  = fill_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Self-checking bench for fft_frame_collector: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_fft_frame_collector;
  localparam int N  = 4;
  localparam int CW = 16;
  localparam int FW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [31:0]   sData;
  logic          sValid;
  logic          frameReady;
  logic          sReady;
  logic          frameValid;
  logic [31:0]   frame [0:N-1];
  logic [FW-1:0] fillLevel;
  logic [CW-1:0] frameCnt;

  // A second instance with a narrow counter makes the wrap reachable quickly.
  logic          wReady;
  logic          wValid;
  logic [31:0]   wFrame [0:N-1];
  logic [FW-1:0] wFill;
  logic [3:0]    wCnt;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fft_frame_collector #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .s_data(sData), .s_valid(sValid), .s_ready(sReady),
    .frame(frame), .frame_valid(frameValid), .frame_ready(frameReady),
    .fill_level(fillLevel), .frame_cnt(frameCnt)
  );

  fft_frame_collector #(.N(N), .CW(4)) dutWrap (
    .clk(clk), .rst(rst), .clear(clear),
    .s_data(sData), .s_valid(sValid), .s_ready(wReady),
    .frame(wFrame), .frame_valid(wValid), .frame_ready(frameReady),
    .fill_level(wFill), .frame_cnt(wCnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: samples gathered since the last frame handoff live in a queue;
  // a full queue moves to the output whenever the output slot is free.
  logic [31:0] mColl [$];
  logic [31:0] mFrame [0:N-1];
  bit          mValid;
  int unsigned mCnt;
  bit          mPop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mColl.delete();
      for (int i = 0; i < N; i++) mFrame[i] = '0;
      mValid = 1'b0;
      mCnt   = 0;
    end else begin
      mPop = mValid && frameReady;
      if (clear) begin
        mColl.delete();
        if (mPop) mValid = 1'b0;
      end else begin
        if (sValid && (mColl.size() < N)) mColl.push_back(sData);
        if ((mColl.size() == N) && (!mValid || frameReady)) begin
          for (int i = 0; i < N; i++) mFrame[i] = mColl[i];
          mColl.delete();
          mValid = 1'b1;
          mCnt++;
        end else if (mPop) begin
          mValid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("s_ready", 32'(sReady), 32'(mColl.size() < N));
    checkOutput("frame_valid", 32'(frameValid), 32'(mValid));
    checkOutput("fill_level", 32'(fillLevel), 32'(mColl.size()));
    checkOutput("frame_cnt", 32'(frameCnt), 32'(mCnt % 65536));
    checkOutput("wrap_cnt", 32'(wCnt), 32'(mCnt % 16));
    for (int i = 0; i < N; i++) checkOutput($sformatf("frame[%0d]", i), frame[i], mFrame[i]);
  end

  // Offer one sample and return just after the edge on which it was accepted.
  task automatic applyStimulus(input logic [31:0] d);
    int budget;
    budget = 50;
    sValid = 1'b1;
    sData  = d;
    while (!sReady && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (!sReady) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: sample %0d, s_ready got 0, expected 1", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendRange(input int first, input int count);
    for (int v = first; v < first + count; v++) applyStimulus(32'(v));
    sValid = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkFrame(input string name, input int first);
    for (int i = 0; i < N; i++) checkOutput($sformatf("%s[%0d]", name, i), frame[i], 32'(first + i));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; sValid = 1'b0; sData = '0; frameReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(frameValid), 32'd0);
    checkOutput("reset_ready", 32'(sReady), 32'd1);
    checkOutput("reset_frame0", frame[0], 32'd0);
    rst = 1'b0;

    // Basic fill
    sendRange(1, 4);
    checkOutput("basic_valid", 32'(frameValid), 32'd1);
    checkFrame("basic_frame", 1);
    checkOutput("basic_cnt", 32'(frameCnt), 32'd1);
    checkOutput("basic_fill", 32'(fillLevel), 32'd0);

    // Continuous stream
    pulseReset();
    sendRange(1, 12);
    checkFrame("cont_frame", 9);
    checkOutput("cont_cnt", 32'(frameCnt), 32'd3);

    // Backpressure
    pulseReset();
    frameReady = 1'b0;
    sendRange(1, 8);
    checkFrame("bp_held", 1);
    checkOutput("bp_ready", 32'(sReady), 32'd0);
    checkOutput("bp_fill", 32'(fillLevel), 32'd4);
    frameReady = 1'b1;
    @(posedge clk);
    #1;
    frameReady = 1'b0;
    checkFrame("bp_next", 5);
    checkOutput("bp_valid", 32'(frameValid), 32'd1);
    checkOutput("bp_ready_after", 32'(sReady), 32'd1);
    checkOutput("bp_cnt", 32'(frameCnt), 32'd2);
    frameReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Clear
    pulseReset();
    sendRange(1, 2);
    sValid = 1'b1; sData = 32'd3; clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; sValid = 1'b0;
    checkOutput("clear_fill", 32'(fillLevel), 32'd0);
    sendRange(10, 4);
    checkFrame("clear_frame", 10);
    checkOutput("clear_cnt", 32'(frameCnt), 32'd1);

    // Async reset mid-frame with a held frame on the output
    pulseReset();
    frameReady = 1'b0;
    sendRange(20, 4);
    sendRange(1, 3);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(frameValid), 32'd0);
    checkOutput("arst_fill", 32'(fillLevel), 32'd0);
    checkOutput("arst_ready", 32'(sReady), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    frameReady = 1'b1;
    sendRange(5, 4);
    checkFrame("arst_frame", 5);
    checkOutput("arst_cnt", 32'(frameCnt), 32'd1);

    // Counter wrap on the 4-bit instance
    pulseReset();
    sendRange(1, 16 * N);
    checkOutput("wrap_zero", 32'(wCnt), 32'd0);
    checkOutput("wrap_main", 32'(frameCnt), 32'd16);
    sendRange(100, N);
    checkOutput("wrap_one", 32'(wCnt), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
